// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs field-level operations from the program loader into 32-bit instruction
// words and buffers them in a first-word-fall-through FIFO. The control unit
// reads one word at a time from the head of the FIFO.
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset, discards all buffered words
//   in_valid     loader presents an operation
//   in_ready     encoder can accept (FIFO not full)
//   in_opcode    8-bit operation code
//   in_dest      destination register address
//   in_src1      source-1 register address (ignored for LOADI)
//   in_src2      source-2 register address (ignored for LOADI)
//   in_imm       immediate value (LOADI only)
//   instr_out    head-of-FIFO instruction word, 0 when empty
//   instr_valid  instr_out holds a valid word
//   instr_ready  control unit consumes the head word this cycle
//   err_opcode   one-cycle pulse after an illegal opcode is rejected
//   count        number of buffered words
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Neither ready depends on the matching valid, and the producer
// keeps its fields stable while valid=1 and ready=0. When full, in_ready
// stays low even if a pop happens in the same cycle (no bypass).
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_opcode,
  input  logic [2:0]               in_dest,
  input  logic [2:0]               in_src1,
  input  logic [2:0]               in_src2,
  input  logic [7:0]               in_imm,
  output logic [31:0]              instr_out,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     err_opcode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] OP_MOV   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_LOADI = 8'h08;
  localparam logic [7:0] OP_SUB   = 8'h09;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic          w_legal;
  logic [31:0]   w_word;
  logic          w_push;
  logic          w_pop;
  logic          w_reject;
  logic          w_full;
  logic          w_empty;

  always_comb begin
    w_legal = 1'b0;
    case (in_opcode)
      OP_MOV, OP_ADD, OP_AND, OP_OR, OP_LOADI, OP_SUB: w_legal = 1'b1;
      default:                                         w_legal = 1'b0;
    endcase
  end

  // LOADI carries the immediate in the low byte; everything else carries
  // src2 in [10:8] and a zero-extended src1 in [7:0].
  always_comb begin
    if (in_opcode == OP_LOADI) begin
      w_word = {in_opcode, 5'b0, in_dest, 5'b0, 3'b0, in_imm};
    end else begin
      w_word = {in_opcode, 5'b0, in_dest, 5'b0, in_src2, 5'b0, in_src1};
    end
  end

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid && !w_full && w_legal;
  assign w_reject = in_valid && !w_full && !w_legal;
  assign w_pop    = !w_empty && instr_ready;

  // Storage is not reset: contents are only ever observed through the read
  // pointer while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready    = !w_full;
  assign instr_valid = !w_empty;
  assign instr_out   = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign err_opcode  = r_err;
  assign count       = r_count;

endmodule
